dac_spi_tx: RTL

Quad motor-current DAC transmitter for the QLA board: the command-side counterpart of the ADC feedback path. Holds one 16-bit setpoint per axis (1–4), accepts setpoint writes from the register file, and shifts all four setpoints to a daisy-chain of four LTC2601-class SPI DACs sharing one chip-select. Any accepted write schedules a full 96-bit frame. Frames never interleave; writes during a frame are coalesced into one follow-up frame.

---
 rtl/dac_spi_tx_if.sv | 18 +
 rtl/dac_spi_tx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dac_spi_tx_if.sv
// Register-file side of the DAC transmitter: setpoint writes and combinational readback.
interface dac_spi_tx_if;
  logic [15:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_wen;
  logic [15:0] reg_raddr;
  logic [31:0] reg_rdata;

  modport master (
    output reg_waddr, reg_wdata, reg_wen, reg_raddr,
    input  reg_rdata
  );

  modport slave (
    input  reg_waddr, reg_wdata, reg_wen, reg_raddr,
    output reg_rdata
  );
endinterface

// File: rtl/dac_spi_tx.sv
// Quad setpoint holder that shifts a 96-bit frame to a daisy chain of four SPI DACs.
// Writes made while a frame is in flight coalesce into a single follow-up frame.
module dac_spi_tx #(
  parameter logic [3:0] CMD     = 4'b0011,
  parameter int         CS_HOLD = 4
) (
  input  logic         clk,
  input  logic         reset,
  dac_spi_tx_if.slave  bus,
  output logic         sclk,
  output logic         csn,
  output logic         mosi,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, HOLD} state_t;

  state_t       state_reg, state_next;
  logic [15:0]  val_reg [4];
  logic         pending_reg;
  logic [95:0]  shift_reg, shift_next;
  logic [6:0]   bit_reg, bit_next;
  logic [7:0]   hold_reg, hold_next;
  logic         csn_reg, csn_next;
  logic         sclk_reg, sclk_next;
  logic         mosi_reg, mosi_next;
  logic         load;
  logic [95:0]  frame;

  logic [3:0]   waxis, raxis;
  logic         wr_hit;
  logic [1:0]   ridx;

  assign waxis  = bus.reg_waddr[7:4];
  assign raxis  = bus.reg_raddr[7:4];
  assign wr_hit = bus.reg_wen && (waxis >= 4'd1) && (waxis <= 4'd4);
  assign ridx   = 2'(raxis - 4'd1);

  logic unused_bits;
  assign unused_bits = ^{bus.reg_waddr[15:8], bus.reg_waddr[3:0], bus.reg_wdata[31:16],
                         bus.reg_raddr[15:8], bus.reg_raddr[3:0]};

  // Word for axis N sits at bits [24N-1 -: 24], so axis 4 leaves first and reaches the far DAC.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_word
      assign frame[24*gi +: 24] = {CMD, 4'b0000, val_reg[gi]};
    end
  endgenerate

  always_comb begin
    bus.reg_rdata = 32'h0000_0000;
    if ((raxis >= 4'd1) && (raxis <= 4'd4))
      bus.reg_rdata = {16'h0000, val_reg[ridx]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) val_reg[i] <= 16'h8000;
    end else if (wr_hit) begin
      val_reg[2'(waxis - 4'd1)] <= bus.reg_wdata[15:0];
    end
  end

  // Reset leaves pending set so a midscale frame goes out right after reset; a write beats a load.
  always_ff @(posedge clk) begin
    if (reset)       pending_reg <= 1'b1;
    else if (wr_hit) pending_reg <= 1'b1;
    else if (load)   pending_reg <= 1'b0;
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    bit_next   = bit_reg;
    hold_next  = hold_reg;
    csn_next   = csn_reg;
    sclk_next  = sclk_reg;
    mosi_next  = mosi_reg;
    load       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          load       = 1'b1;
          shift_next = frame;
          bit_next   = 7'd95;
          csn_next   = 1'b0;
          sclk_next  = 1'b0;
          mosi_next  = frame[95];
          state_next = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        sclk_next  = 1'b1;
        state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        sclk_next = 1'b0;
        if (bit_reg == 7'd0) begin
          csn_next   = 1'b1;
          mosi_next  = 1'b0;
          hold_next  = 8'(CS_HOLD - 1);
          state_next = HOLD;
        end else begin
          bit_next   = bit_reg - 7'd1;
          shift_next = {shift_reg[94:0], 1'b0};
          mosi_next  = shift_reg[94];
          state_next = SHIFT_LO;
        end
      end
      HOLD: begin
        if (hold_reg == 8'd0) state_next = IDLE;
        else                  hold_next  = hold_reg - 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      bit_reg   <= '0;
      hold_reg  <= '0;
      csn_reg   <= 1'b1;
      sclk_reg  <= 1'b0;
      mosi_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      bit_reg   <= bit_next;
      hold_reg  <= hold_next;
      csn_reg   <= csn_next;
      sclk_reg  <= sclk_next;
      mosi_reg  <= mosi_next;
    end
  end

  assign csn  = csn_reg;
  assign sclk = sclk_reg;
  assign mosi = mosi_reg;
  assign busy = (state_reg != IDLE);

endmodule
